forward_layer_engine: RTL and testbench

//  Forward-pass producer for the backpropagator: consumes one layer's weight matrix and input activation vector.

---
 rtl/forward_layer_engine_pkg.sv | 26 ++
 rtl/forward_layer_engine_if.sv | 36 +++
 rtl/forward_layer_engine_dot_product_row.sv | 50 +++++
 rtl/forward_layer_engine.sv | 167 ++++++++++++++++
 tb/tb_forward_layer_engine.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/forward_layer_engine_pkg.sv
// Shared definitions for the forward layer engine and the backpropagator updater:
// FSM state encoding, default geometry and the signed saturation-detect macro.
`ifndef FORWARD_LAYER_ENGINE_PKG_SV
`define FORWARD_LAYER_ENGINE_PKG_SV

// True when signed variable x does not fit in `width` bits (its top bits are not a pure sign copy).
`define SAT_SIGNED(x, width) (!((&(x[$bits(x)-1:(width)-1])) || (~|(x[$bits(x)-1:(width)-1]))))

package forward_layer_engine_pkg;

  localparam int DEF_NEURON_NUM          = 4;
  localparam int DEF_NEURON_OUTPUT_WIDTH = 10;
  localparam int DEF_ACTIVATION_WIDTH    = 9;
  localparam int DEF_WEIGHT_CELL_WIDTH   = 16;
  localparam int DEF_FRACTION_WIDTH      = 8;
  localparam int DEF_LAYER_ADDR_WIDTH    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } fle_state_e;

endpackage

`endif

// File: rtl/forward_layer_engine_if.sv
// Handshake bundle between the weight/activation sources, the forward engine and the backpropagator.
interface forward_layer_engine_if #(
  parameter int NEURON_NUM          = forward_layer_engine_pkg::DEF_NEURON_NUM,
  parameter int NEURON_OUTPUT_WIDTH = forward_layer_engine_pkg::DEF_NEURON_OUTPUT_WIDTH,
  parameter int ACTIVATION_WIDTH    = forward_layer_engine_pkg::DEF_ACTIVATION_WIDTH,
  parameter int WEIGHT_CELL_WIDTH   = forward_layer_engine_pkg::DEF_WEIGHT_CELL_WIDTH,
  parameter int LAYER_ADDR_WIDTH    = forward_layer_engine_pkg::DEF_LAYER_ADDR_WIDTH
);

  logic [LAYER_ADDR_WIDTH-1:0]                          layer;
  logic                                                 layer_valid;
  logic                                                 layer_ready;
  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]               a;
  logic                                                 a_valid;
  logic                                                 a_ready;
  logic [NEURON_NUM*NEURON_NUM*WEIGHT_CELL_WIDTH-1:0]   weights;
  logic                                                 weights_valid;
  logic                                                 weights_ready;
  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]            z;
  logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]            z_prev;
  logic [LAYER_ADDR_WIDTH-1:0]                          z_layer;
  logic                                                 z_valid;
  logic                                                 z_ready;
  logic                                                 error;

  modport master (
    output layer, layer_valid, a, a_valid, weights, weights_valid, z_ready,
    input  layer_ready, a_ready, weights_ready, z, z_prev, z_layer, z_valid, error
  );

  modport slave (
    input  layer, layer_valid, a, a_valid, weights, weights_valid, z_ready,
    output layer_ready, a_ready, weights_ready, z, z_prev, z_layer, z_valid, error
  );

endinterface

// File: rtl/forward_layer_engine_dot_product_row.sv
// Combinational N-wide signed MAC of one weight row against unsigned activations,
// followed by a floor shift of the fraction bits and signed saturation.
module forward_layer_engine_dot_product_row #(
  parameter int NEURON_NUM          = 4,
  parameter int NEURON_OUTPUT_WIDTH = 10,
  parameter int ACTIVATION_WIDTH    = 9,
  parameter int WEIGHT_CELL_WIDTH   = 16,
  parameter int FRACTION_WIDTH      = 8
) (
  input  logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]  a,
  input  logic [NEURON_NUM*WEIGHT_CELL_WIDTH-1:0] w_row,
  output logic signed [NEURON_OUTPUT_WIDTH-1:0]   result,
  output logic                                    sat
);

  localparam int N  = NEURON_NUM;
  localparam int OW = NEURON_OUTPUT_WIDTH;
  localparam int AW = ACTIVATION_WIDTH;
  localparam int WW = WEIGHT_CELL_WIDTH;
  localparam int FW = FRACTION_WIDTH;
  localparam int SW = WW + AW + 1 + ((N > 1) ? $clog2(N) : 1);

  // Returns {sat, value}: floor-shift then clamp to the signed OW range.
  function automatic logic [OW:0] shift_sat(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] s;
    logic [OW:0]          r;
    s = x >>> FW;
    if (`SAT_SIGNED(s, OW)) begin
      r = s[SW-1] ? {1'b1, 1'b1, {(OW-1){1'b0}}} : {1'b1, 1'b0, {(OW-1){1'b1}}};
    end else begin
      r = {1'b0, s[OW-1:0]};
    end
    return r;
  endfunction

  logic signed [SW-1:0] acc;
  logic [OW:0]          packed_res;

  always_comb begin
    acc = '0;
    for (int j = 0; j < N; j++) begin
      acc = acc + (SW'($signed(w_row[j*WW +: WW])) * SW'($signed({1'b0, a[j*AW +: AW]})));
    end
    packed_res = shift_sat(acc);
  end

  assign sat    = packed_res[OW];
  assign result = packed_res[OW-1:0];

endmodule

// File: rtl/forward_layer_engine.sv
// Forward pass producer: captures layer/a/W independently, computes z = W*a one row per
// cycle, then presents z with the previous pass's z until the backpropagator accepts it.
module forward_layer_engine
  import forward_layer_engine_pkg::*;
#(
  parameter int NEURON_NUM          = DEF_NEURON_NUM,
  parameter int NEURON_OUTPUT_WIDTH = DEF_NEURON_OUTPUT_WIDTH,
  parameter int ACTIVATION_WIDTH    = DEF_ACTIVATION_WIDTH,
  parameter int WEIGHT_CELL_WIDTH   = DEF_WEIGHT_CELL_WIDTH,
  parameter int FRACTION_WIDTH      = DEF_FRACTION_WIDTH,
  parameter int LAYER_ADDR_WIDTH    = DEF_LAYER_ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  forward_layer_engine_if.slave  bus
);

  localparam int N  = NEURON_NUM;
  localparam int OW = NEURON_OUTPUT_WIDTH;
  localparam int AW = ACTIVATION_WIDTH;
  localparam int WW = WEIGHT_CELL_WIDTH;
  localparam int LW = LAYER_ADDR_WIDTH;
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  fle_state_e               state_q, state_d;
  logic [RW-1:0]            row_q, row_d;
  logic                     cap_layer_q, cap_layer_d;
  logic                     cap_a_q, cap_a_d;
  logic                     cap_w_q, cap_w_d;
  logic [LW-1:0]            layer_q, layer_d;
  logic [N*AW-1:0]          a_q, a_d;
  logic [N*N*WW-1:0]        w_q, w_d;
  logic signed [OW-1:0]     z_reg_q [N];
  logic signed [OW-1:0]     z_reg_d [N];
  logic signed [OW-1:0]     z_prev_reg_q [N];
  logic signed [OW-1:0]     z_prev_reg_d [N];
  logic                     error_q, error_d;

  logic                     layer_rdy, a_rdy, w_rdy;
  logic [N*WW-1:0]          w_row;
  logic signed [OW-1:0]     row_result;
  logic                     row_sat;
  logic [N*OW-1:0]          z_flat, zp_flat;

  assign layer_rdy = (state_q == IDLE) && !cap_layer_q;
  assign a_rdy     = (state_q == IDLE) && !cap_a_q;
  assign w_rdy     = (state_q == IDLE) && !cap_w_q;
  assign w_row     = w_q[row_q*(N*WW) +: N*WW];

  forward_layer_engine_dot_product_row #(
    .NEURON_NUM          (N),
    .NEURON_OUTPUT_WIDTH (OW),
    .ACTIVATION_WIDTH    (AW),
    .WEIGHT_CELL_WIDTH   (WW),
    .FRACTION_WIDTH      (FRACTION_WIDTH)
  ) u_row (
    .a      (a_q),
    .w_row  (w_row),
    .result (row_result),
    .sat    (row_sat)
  );

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    cap_layer_d  = cap_layer_q;
    cap_a_d      = cap_a_q;
    cap_w_d      = cap_w_q;
    layer_d      = layer_q;
    a_d          = a_q;
    w_d          = w_q;
    z_reg_d      = z_reg_q;
    z_prev_reg_d = z_prev_reg_q;
    error_d      = error_q;
    case (state_q)
      IDLE: begin
        if (bus.layer_valid && layer_rdy) begin
          cap_layer_d = 1'b1;
          layer_d     = bus.layer;
        end
        if (bus.a_valid && a_rdy) begin
          cap_a_d = 1'b1;
          a_d     = bus.a;
        end
        if (bus.weights_valid && w_rdy) begin
          cap_w_d = 1'b1;
          w_d     = bus.weights;
        end
        if (cap_layer_d && cap_a_d && cap_w_d) begin
          state_d = COMPUTE;
          row_d   = '0;
        end
      end
      COMPUTE: begin
        z_reg_d[row_q] = row_result;
        if (row_sat) error_d = 1'b1;
        if (row_q == RW'(N-1)) begin
          state_d = OUTPUT;
          row_d   = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      OUTPUT: begin
        if (bus.z_ready) begin
          z_prev_reg_d = z_reg_q;
          cap_layer_d  = 1'b0;
          cap_a_d      = 1'b0;
          cap_w_d      = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      cap_layer_q <= 1'b0;
      cap_a_q     <= 1'b0;
      cap_w_q     <= 1'b0;
      layer_q     <= '0;
      error_q     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        z_reg_q[i]      <= '0;
        z_prev_reg_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      cap_layer_q  <= cap_layer_d;
      cap_a_q      <= cap_a_d;
      cap_w_q      <= cap_w_d;
      layer_q      <= layer_d;
      error_q      <= error_d;
      z_reg_q      <= z_reg_d;
      z_prev_reg_q <= z_prev_reg_d;
    end
  end

  // Operand holding registers: only read after their capture flag is set.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    w_q <= w_d;
  end

  always_comb begin
    z_flat  = '0;
    zp_flat = '0;
    for (int i = 0; i < N; i++) begin
      z_flat[i*OW +: OW]  = z_reg_q[i];
      zp_flat[i*OW +: OW] = z_prev_reg_q[i];
    end
  end

  assign bus.layer_ready   = layer_rdy;
  assign bus.a_ready       = a_rdy;
  assign bus.weights_ready = w_rdy;
  assign bus.z             = z_flat;
  assign bus.z_prev        = (layer_q == '0) ? '0 : zp_flat;
  assign bus.z_layer       = layer_q;
  assign bus.z_valid       = (state_q == OUTPUT);
  assign bus.error         = error_q;

endmodule

// File: tb/tb_forward_layer_engine.sv
// Self-checking bench for forward_layer_engine: directed scenarios plus randomized passes
// checked against an arithmetic model of z = sat((W*a) >>> FW).
module tb_forward_layer_engine;

  localparam int N  = 4;
  localparam int OW = 10;
  localparam int AW = 9;
  localparam int WW = 16;
  localparam int FW = 8;
  localparam int LW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  forward_layer_engine_if bus ();

  forward_layer_engine dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cap_cyc = 0;
  int rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N*OW-1:0] z;
    logic [LW-1:0]   layer;
    bit              sat;
  } exp_t;

  exp_t exp_q[$];
  logic [N*OW-1:0] seen_z, seen_zprev;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic void model_pass(input logic [N*AW-1:0] av, input logic [N*N*WW-1:0] wv,
                                     output logic [N*OW-1:0] zv, output bit sat);
    longint s, q;
    logic signed [WW-1:0] ws;
    logic [63:0] qb;
    longint maxv, minv;
    maxv = (longint'(1) <<< (OW-1)) - 1;
    minv = -(longint'(1) <<< (OW-1));
    sat = 1'b0;
    zv = '0;
    for (int i = 0; i < N; i++) begin
      s = 0;
      for (int j = 0; j < N; j++) begin
        ws = wv[(i*N+j)*WW +: WW];
        s += longint'(ws) * longint'(av[j*AW +: AW]);
      end
      q = s >>> FW;
      if (q > maxv) begin q = maxv; sat = 1'b1; end
      else if (q < minv) begin q = minv; sat = 1'b1; end
      qb = q;
      zv[i*OW +: OW] = qb[OW-1:0];
    end
  endfunction

  // z_ready generator, updated away from the sampling edge
  initial begin
    bus.z_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0: bus.z_ready = 1'b1;
        1: bus.z_ready = 1'b0;
        default: bus.z_ready = ($urandom_range(0, 1) == 1);
      endcase
    end
  end

  // Compare process: stability under backpressure, latency, and every accepted output
  initial begin
    logic [N*OW-1:0] last_z_m;
    bit err_m, held, prev_valid;
    logic [N*OW-1:0] h_z, h_zp, exp_prev;
    logic [LW-1:0] h_l;
    exp_t e;
    last_z_m = '0; err_m = 0; held = 0; prev_valid = 0;
    h_z = '0; h_zp = '0; h_l = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        last_z_m = '0;
        err_m = 0;
        held = 0;
        prev_valid = 0;
      end else begin
        if (held) begin
          check("hold_valid", bus.z_valid, 1);
          check("hold_z", bus.z, h_z);
          check("hold_zprev", bus.z_prev, h_zp);
          check("hold_layer", bus.z_layer, h_l);
        end
        if (bus.z_valid && !prev_valid) check("latency", cyc - cap_cyc, N + 1);
        if (bus.z_valid && bus.z_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            exp_prev = (e.layer == '0) ? '0 : last_z_m;
            err_m = err_m | e.sat;
            check("z", bus.z, e.z);
            check("z_prev", bus.z_prev, exp_prev);
            check("z_layer", bus.z_layer, e.layer);
            check("error", bus.error, err_m);
            last_z_m = e.z;
            seen_z = bus.z;
            seen_zprev = bus.z_prev;
          end
        end
        held = bus.z_valid && !bus.z_ready;
        h_z = bus.z; h_zp = bus.z_prev; h_l = bus.z_layer;
        prev_valid = bus.z_valid;
      end
    end
  end

  task automatic send(input logic [LW-1:0] l, input logic [N*AW-1:0] av,
                      input logic [N*N*WW-1:0] wv, input int dl, input int da, input int dw);
    bit dn_l, dn_a, dn_w, f_l, f_a, f_w;
    int t;
    exp_t e;
    dn_l = 0; dn_a = 0; dn_w = 0; f_l = 0; f_a = 0; f_w = 0; t = 0;
    while (t < 300) begin
      @(posedge clk);
      #1;
      if (f_l) begin dn_l = 1; f_l = 0; bus.layer_valid = 1'b0; end
      if (f_a) begin dn_a = 1; f_a = 0; bus.a_valid = 1'b0; end
      if (f_w) begin dn_w = 1; f_w = 0; bus.weights_valid = 1'b0; end
      if (dn_l && dn_a && dn_w) break;
      if (!dn_l && t >= dl) begin bus.layer = l; bus.layer_valid = 1'b1; end
      if (!dn_a && t >= da) begin bus.a = av; bus.a_valid = 1'b1; end
      if (!dn_w && t >= dw) begin bus.weights = wv; bus.weights_valid = 1'b1; end
      t++;
      @(negedge clk);
      if (bus.layer_valid && bus.layer_ready) begin f_l = 1; cap_cyc = cyc; end
      if (bus.a_valid && bus.a_ready) begin f_a = 1; cap_cyc = cyc; end
      if (bus.weights_valid && bus.weights_ready) begin f_w = 1; cap_cyc = cyc; end
    end
    check("send_done", dn_l && dn_a && dn_w, 1);
    model_pass(av, wv, e.z, e.sat);
    e.layer = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.z_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", (t < 200), 1);
    @(negedge clk);
  endtask

  initial begin
    logic [N*N*WW-1:0] w_id, w_neg, w_max, wr;
    logic [N*AW-1:0] a1, a_max, a_256, ar, a_b;
    logic [N*OW-1:0] lit1, lit_neg, lit_max, mz, first_z;
    bit msat;
    int lit1_cells[N];
    int d[3];
    int tmp, k, v;

    lit1_cells = '{0, 64, 128, 256};
    w_id = '0; w_neg = '0; w_max = '0;
    a1 = '0; a_max = '0; a_256 = '0; a_b = '0;
    lit1 = '0; lit_neg = '0; lit_max = '0;
    for (int i = 0; i < N; i++) begin
      a1[i*AW +: AW]    = AW'(lit1_cells[i]);
      a_b[i*AW +: AW]   = AW'(100 + 30 * i);
      a_max[i*AW +: AW] = '1;
      a_256[i*AW +: AW] = AW'(256);
      lit1[i*OW +: OW]    = OW'(lit1_cells[i]);
      lit_neg[i*OW +: OW] = 10'h300;
      lit_max[i*OW +: OW] = 10'd511;
      for (int j = 0; j < N; j++) begin
        w_id[(i*N+j)*WW +: WW]  = (i == j) ? 16'd256 : 16'd0;
        w_neg[(i*N+j)*WW +: WW] = (i == j) ? 16'hFF00 : 16'd0;
        w_max[(i*N+j)*WW +: WW] = 16'h7FFF;
      end
    end

    rst = 1'b1;
    bus.layer = '0; bus.layer_valid = 1'b0;
    bus.a = '0; bus.a_valid = 1'b0;
    bus.weights = '0; bus.weights_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_z_valid", bus.z_valid, 0);
    check("rst_z", bus.z, 0);
    check("rst_z_prev", bus.z_prev, 0);
    check("rst_z_layer", bus.z_layer, 0);
    check("rst_error", bus.error, 0);
    check("rst_layer_ready", bus.layer_ready, 1);
    check("rst_a_ready", bus.a_ready, 1);
    check("rst_w_ready", bus.weights_ready, 1);

    // Hand-computed values pinning the model
    model_pass(a1, w_id, mz, msat);
    check("model_identity", mz, lit1);
    check("model_identity_sat", msat, 0);
    model_pass(a_max, w_max, mz, msat);
    check("model_max", mz, lit_max);
    check("model_max_sat", msat, 1);
    model_pass(a_256, w_neg, mz, msat);
    check("model_neg", mz, lit_neg);

    // Identity, all inputs in one cycle
    send(2'd1, a1, w_id, 0, 0, 0);
    wait_idle();
    check("s1_z", seen_z, lit1);
    check("s1_error", bus.error, 0);

    // Three inputs in separate cycles, random order
    d = '{0, 1, 2};
    for (int i = 2; i > 0; i--) begin
      k = $urandom_range(0, i);
      tmp = d[i]; d[i] = d[k]; d[k] = tmp;
    end
    send(2'd1, a1, w_id, d[0], d[1], d[2]);
    wait_idle();
    check("s1_split_z", seen_z, lit1);

    // Negative diagonal
    send(2'd3, a_256, w_neg, 0, 0, 0);
    wait_idle();
    check("s3_z", seen_z, lit_neg);
    check("s3_error", bus.error, 0);

    // layer 0 then layer 1: z_prev chaining
    send(2'd0, a1, w_id, 0, 0, 0);
    wait_idle();
    check("s4_zprev_l0", seen_zprev, 0);
    first_z = seen_z;
    send(2'd1, a_b, w_id, 1, 0, 2);
    wait_idle();
    check("s4_zprev_l1", seen_zprev, first_z);

    // Backpressure for 10 cycles
    rdy_mode = 1;
    send(2'd2, a_b, w_neg, 0, 2, 1);
    k = 0;
    while (!bus.z_valid && k < 50) begin @(negedge clk); k++; end
    check("s5_valid_rise", bus.z_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("s5_valid", bus.z_valid, 1);
      check("s5_rdy", {bus.layer_ready, bus.a_ready, bus.weights_ready}, 0);
    end
    rdy_mode = 0;
    wait_idle();
    check("s5_idle_rdy", {bus.layer_ready, bus.a_ready, bus.weights_ready}, 3'b111);

    // Saturation, then error stays set across a clean pass
    send(2'd1, a_max, w_max, 0, 0, 0);
    wait_idle();
    check("s2_z", seen_z, lit_max);
    check("s2_error", bus.error, 1);
    send(2'd1, a1, w_id, 0, 0, 0);
    wait_idle();
    check("s2_error_sticky", bus.error, 1);

    // Randomized passes with random ordering and backpressure
    rdy_mode = 2;
    for (int p = 0; p < 25; p++) begin
      wr = '0; ar = '0;
      for (int c = 0; c < N*N; c++) begin
        v = ($urandom_range(0, 3) == 0) ? int'($urandom) : ($urandom_range(0, 1023) - 512);
        wr[c*WW +: WW] = v[15:0];
      end
      for (int c = 0; c < N; c++) ar[c*AW +: AW] = AW'($urandom_range(0, 511));
      send(LW'($urandom_range(0, 3)), ar, wr,
           $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
    end
    wait_idle();
    rdy_mode = 0;

    // Reset mid-COMPUTE at row 2
    send(2'd2, a1, w_id, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("s6_z_valid", bus.z_valid, 0);
    check("s6_z", bus.z, 0);
    check("s6_error", bus.error, 0);
    check("s6_rdy", {bus.layer_ready, bus.a_ready, bus.weights_ready}, 3'b111);
    repeat (8) begin
      @(negedge clk);
      check("s6_no_output", bus.z_valid, 0);
    end
    send(2'd1, a1, w_id, 0, 0, 0);
    wait_idle();
    check("s6_after_z", seen_z, lit1);
    check("s6_after_zprev", seen_zprev, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
